// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, GF(2^8) helpers, Rcon, FSM state and byte/column helpers.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef enum logic [1:0] {BOSTA, TUR, HAZIR} durum_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Entries past round 10 continue the xtime sequence for reduced/extended test builds.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      4'd11:   return 8'h6c;
      4'd12:   return 8'hd8;
      4'd13:   return 8'hab;
      4'd14:   return 8'h4d;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] sutun(input logic [127:0] s, input logic [1:0] c);
    logic [127:0] t;
    t = s << (32 * c);
    return t[127:96];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      o[127-32*c -: 32] = sub_word(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte i sits at [127-8i -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sutun_karistirma.sv
// MixColumns on one 32-bit state column (row 0 in the top byte).
module aes_sutun_karistirma
  import aes_pkg::*;
(
  input  logic [31:0] sutun_i,
  output logic [31:0] sutun_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = sutun_i;

  assign sutun_o = {
    gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
    a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
    a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
    gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)
  };

endmodule

// File: rtl/aes_sifreleme_cekirdegi.sv
// Iterative AES-128 encryption core, one block at a time, key expanded on the fly.
// Define AES_SON_ANAHTAR_EN to expose the round-NR key on son_anahtar.
module aes_sifreleme_cekirdegi
  import aes_pkg::*;
#(
  parameter int unsigned NR         = NR_AES128,
  parameter int unsigned SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] duz_metin,
  input  logic [127:0] anahtar,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sifreli
`ifdef AES_SON_ANAHTAR_EN
  ,
  output logic [127:0] son_anahtar
`endif
);

  if (SBOX_LANES != 16 && SBOX_LANES != 4) begin : g_lane_hata
    $error("SBOX_LANES must be 16 or 4");
  end
  if (NR < 2 || NR > 14) begin : g_nr_hata
    $error("NR must be in 2..14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  durum_e       durum_q;
  logic [127:0] state_q, rk_q, sifreli_q;
  logic [3:0]   rnd_q;
  logic         out_valid_q;

  logic [127:0] sb_full, sr, mc, tur_d, rk_d;
  logic [31:0]  w3, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic         adim, son_tur, kabul;

  assign w3  = rk_q[31:0];
  assign t_w = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_q), 24'h0};
  assign n0  = rk_q[127:96] ^ t_w;
  assign n1  = rk_q[95:64]  ^ n0;
  assign n2  = rk_q[63:32]  ^ n1;
  assign n3  = w3           ^ n2;
  assign rk_d = {n0, n1, n2, n3};

  if (SBOX_LANES == 4) begin : g_lane4
    logic [1:0]  alt_q;
    logic [95:0] gecici_q;
    logic [31:0] col_sb;

    assign col_sb  = sub_word(sutun(state_q, alt_q));
    // Columns 0..2 shift in over three sub-cycles; column 3 joins combinationally.
    assign sb_full = {gecici_q, col_sb};
    assign adim    = (alt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alt_q    <= '0;
        gecici_q <= '0;
      end else if (durum_q == TUR) begin
        alt_q    <= alt_q + 2'd1;
        gecici_q <= {gecici_q[63:0], col_sb};
      end
    end
  end else begin : g_lane16
    assign sb_full = sub_bytes(state_q);
    assign adim    = 1'b1;
  end

  assign sr = shift_rows(sb_full);

  for (genvar k = 0; k < 4; k++) begin : g_mc
    aes_sutun_karistirma u_mc (
      .sutun_i (sr[127-32*k -: 32]),
      .sutun_o (mc[127-32*k -: 32])
    );
  end

  assign son_tur  = (rnd_q == NR_L);
  assign tur_d    = (son_tur ? sr : mc) ^ rk_d;
  assign in_ready = (durum_q == BOSTA) || ((durum_q == HAZIR) && out_ready);
  assign kabul    = in_valid && in_ready;

`ifdef AES_SON_ANAHTAR_EN
  logic [127:0] son_anahtar_q;
  assign son_anahtar = son_anahtar_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q       <= BOSTA;
      state_q       <= '0;
      rk_q          <= '0;
      rnd_q         <= '0;
      sifreli_q     <= '0;
      out_valid_q   <= 1'b0;
`ifdef AES_SON_ANAHTAR_EN
      son_anahtar_q <= '0;
`endif
    end else begin
      case (durum_q)
        BOSTA, HAZIR: begin
          if (durum_q == HAZIR && out_ready) begin
            out_valid_q <= 1'b0;
            durum_q     <= BOSTA;
          end
          if (kabul) begin
            state_q <= duz_metin ^ anahtar;
            rk_q    <= anahtar;
            rnd_q   <= 4'd1;
            durum_q <= TUR;
          end
        end
        TUR: begin
          if (adim) begin
            state_q <= tur_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_q + 4'd1;
            if (son_tur) begin
              sifreli_q     <= tur_d;
              out_valid_q   <= 1'b1;
`ifdef AES_SON_ANAHTAR_EN
              son_anahtar_q <= rk_d;
`endif
              durum_q       <= HAZIR;
            end
          end
        end
        default: durum_q <= BOSTA;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign sifreli   = sifreli_q;

endmodule
